down_counter_sync: RTL and testbench



---
 rtl/down_counter_sync.sv | 138 +++++++++++++
 tb/tb_down_counter_sync.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/down_counter_sync.sv
// ---------------------------------------------------------------------------
// down_counter_sync
//
// Loadable down counter used as a timeout / delay / interval generator.
// A preset value is counted down to zero. The counter then either stops
// (one-shot) or reloads the preset and keeps running (auto-reload).
//
// Parameters
//   WIDTH    : counter width in bits
//   PRESCALE : enabled cycles per decrement (only with DOWN_CNT_PRESCALE_EN)
//
// Build option
//   DOWN_CNT_PRESCALE_EN : when defined, an internal prescaler counts en-high
//                          cycles. Counting actions then fire only on every
//                          PRESCALE-th enabled cycle.
//
// Ports
//   clk         : clock, all state updates on posedge
//   rst         : asynchronous reset, active-high
//   clear       : synchronous abort to IDLE, no tc (highest priority)
//   load        : load load_val into counter and reload register
//   load_val    : preset value
//   en          : count enable
//   auto_reload : 1 = periodic mode, 0 = one-shot
//   q           : current count (registered)
//   zero        : q == 0
//   tc          : terminal-count pulse, one cycle wide (registered)
//   busy        : counter is in RUN
// ---------------------------------------------------------------------------
module down_counter_sync #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             tc,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] reload_reg;
    logic             step;

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("down_counter_sync: PRESCALE must be >= 1");
    end

    // Decrement that saturates at zero, so the count can never wrap to all-ones.
    function automatic logic [WIDTH-1:0] dec_floor(input logic [WIDTH-1:0] v);
        return (v == '0) ? '0 : v - WIDTH'(1);
    endfunction

`ifdef DOWN_CNT_PRESCALE_EN
    localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic [PW-1:0] pre;

    // Prescaler restarts on clear/load so a fresh count always gets a full
    // PRESCALE enabled cycles before its first decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
        end else if (clear || load) begin
            pre <= '0;
        end else if (en) begin
            pre <= (pre == PMAX) ? '0 : pre + PW'(1);
        end
    end

    assign step = en && (pre == PMAX);
`else
    assign step = en;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q          <= '0;
            reload_reg <= '0;
            state      <= S_IDLE;
            tc         <= 1'b0;
        end else begin
            // tc is a single-cycle pulse; only the q==1 decision raises it.
            tc <= 1'b0;
            if (clear) begin
                q     <= '0;
                state <= S_IDLE;
            end else if (load) begin
                q          <= load_val;
                reload_reg <= load_val;
                state      <= (load_val != '0) ? S_RUN : S_DONE;
            end else begin
                unique case (state)
                    S_IDLE: q <= '0;
                    S_DONE: q <= '0;
                    S_RUN: begin
                        if (step) begin
                            if (q > WIDTH'(1)) begin
                                q <= dec_floor(q);
                            end else if (q == WIDTH'(1)) begin
                                q  <= '0;
                                tc <= 1'b1;
                                if (!auto_reload) state <= S_DONE;
                            end else if (auto_reload) begin
                                // q==0 in periodic mode: start the next period.
                                q <= reload_reg;
                            end else begin
                                // auto_reload dropped while parked at zero.
                                state <= S_DONE;
                            end
                        end
                    end
                    default: begin
                        q     <= '0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign zero = (q == '0);
    assign busy = (state == S_RUN);

endmodule

// File: tb/tb_down_counter_sync.sv
// ---------------------------------------------------------------------------
// tb_down_counter_sync
//
// Directed-vector bench for down_counter_sync (WIDTH=4, PRESCALE=4).
// Inputs change #1 after a rising edge; outputs are sampled at that point.
// ---------------------------------------------------------------------------
module tb_down_counter_sync;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             auto_reload;
    logic [WIDTH-1:0] q;
    logic             zero;
    logic             tc;
    logic             busy;

    int n_cmp;
    int n_mis;

    down_counter_sync #(
        .WIDTH    (WIDTH),
        .PRESCALE (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .load        (load),
        .load_val    (load_val),
        .en          (en),
        .auto_reload (auto_reload),
        .q           (q),
        .zero        (zero),
        .tc          (tc),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int eq, input int etc, input int ebusy);
        chk({tag, ".q"}, int'(q), eq);
        chk({tag, ".tc"}, int'(tc), etc);
        chk({tag, ".busy"}, int'(busy), ebusy);
        chk({tag, ".zero"}, int'(zero), (eq == 0) ? 1 : 0);
    endtask

    task automatic do_load(input int v, input logic ar);
        load_val    = WIDTH'(v);
        auto_reload = ar;
        load        = 1'b1;
        en          = 1'b0;
        tick();
        load        = 1'b0;
    endtask

    int exp_q_auto  [9] = '{1, 0, 2, 1, 0, 2, 1, 0, 2};
    int exp_tc_auto [9] = '{0, 1, 0, 0, 1, 0, 0, 1, 0};
    int exp_q_gate  [8] = '{3, 3, 2, 2, 1, 1, 0, 0};
    int exp_tc_gate [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    int tc_count;

    initial begin
        n_cmp       = 0;
        n_mis       = 0;
        rst         = 1'b1;
        clear       = 1'b0;
        load        = 1'b0;
        load_val    = '0;
        en          = 1'b0;
        auto_reload = 1'b0;
        #12;
        chk_all("reset", 0, 0, 0);
        rst = 1'b0;
        tick();

`ifndef DOWN_CNT_PRESCALE_EN
        // Asynchronous reset mid-count
        do_load(5, 1'b0);
        chk_all("load5", 5, 0, 1);
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0);
        tick();
        rst = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("idle_en", 0, 0, 0);
        end

        // One-shot 3
        do_load(3, 1'b0);
        chk_all("os_load", 3, 0, 1);
        en = 1'b1;
        tick(); chk_all("os_2", 2, 0, 1);
        tick(); chk_all("os_1", 1, 0, 1);
        tick(); chk_all("os_0", 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all("os_hold", 0, 0, 0);
        end

        // Auto-reload 2
        do_load(2, 1'b1);
        chk_all("ar_load", 2, 0, 1);
        en       = 1'b1;
        tc_count = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_all("ar_seq", exp_q_auto[i], exp_tc_auto[i], 1);
            if (tc) tc_count++;
        end
        // Last period: drop auto_reload while parked at zero -> DONE, no tc.
        auto_reload = 1'b0;
        tick();
        chk_all("ar_drop", 0, 0, 0);
        chk("ar_tc_count", tc_count, 3);
        chk("ar_period_q", exp_q_auto[8], 2);

        // Zero load: DONE without tc
        load_val = '0;
        load     = 1'b1;
        en       = 1'b1;
        tick();
        load = 1'b0;
        chk_all("zload", 0, 0, 0);
        tick();
        chk_all("zload_hold", 0, 0, 0);

        // Full range 15 -> 0, no wrap
        do_load(15, 1'b0);
        chk_all("full_load", 15, 0, 1);
        en = 1'b1;
        for (int i = 14; i >= 1; i--) begin
            tick();
            chk_all("full_dn", i, 0, 1);
        end
        tick(); chk_all("full_0", 0, 1, 0);
        tick(); chk_all("full_nowrap", 0, 0, 0);

        // clear beats load
        do_load(7, 1'b0);
        chk_all("cl_load7", 7, 0, 1);
        clear    = 1'b1;
        load     = 1'b1;
        load_val = WIDTH'(9);
        tick();
        clear = 1'b0;
        load  = 1'b0;
        chk_all("clr_load", 0, 0, 0);
        en = 1'b1;
        tick();
        chk_all("clr_idle", 0, 0, 0);

        // Reload during RUN
        do_load(4, 1'b0);
        chk_all("rl_load4", 4, 0, 1);
        en       = 1'b1;
        load     = 1'b1;
        load_val = WIDTH'(9);
        tick();
        load = 1'b0;
        chk_all("rl_9", 9, 0, 1);
        tick();
        chk_all("rl_8", 8, 0, 1);

        // en gating
        do_load(4, 1'b0);
        for (int i = 0; i < 8; i++) begin
            en = (i % 2 == 0);
            tick();
            chk_all("gate", exp_q_gate[i], exp_tc_gate[i], (i < 6) ? 1 : 0);
        end
`else
        // Prescaler: one decrement per 4 enabled cycles
        do_load(2, 1'b0);
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin tick(); chk_all("ps_2", 2, 0, 1); end
        tick(); chk_all("ps_1a", 1, 0, 1);
        for (int i = 0; i < 3; i++) begin tick(); chk_all("ps_1", 1, 0, 1); end
        tick(); chk_all("ps_0", 0, 1, 0);
        tick(); chk_all("ps_tcw", 0, 0, 0);

        // Reload mid-prescale restarts prescaler
        do_load(2, 1'b0);
        en = 1'b1;
        tick(); tick();
        chk_all("ps_mid", 2, 0, 1);
        load     = 1'b1;
        load_val = WIDTH'(2);
        tick();
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin tick(); chk_all("ps_rst", 2, 0, 1); end
        tick(); chk_all("ps_rst1", 1, 0, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
